// File: rtl/axis_if.sv
// AXI-Stream bundle for the PFB test source: source drives data/valid, sink drives ready.
interface axis_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis.sv
// Self-paced AXI-Stream ramp source: a modulo-MAX_CNT schedule counter opens the
// gate for PAUSE cycles per period; the ramp advances on every open edge.
module axis #(
  parameter int    WIDTH   = 16,
  parameter int    MAX_CNT = 32,
  parameter int    START   = 23,
  parameter int    PAUSE   = 24,
  parameter string ORDER   = "processing"
) (
  input  logic   clk,
  input  logic   rst,
  axis_if.master m_axis
);

  localparam int unsigned   CW        = $clog2(MAX_CNT);
  localparam logic [CW-1:0] CTR_INIT  = CW'(START);
  localparam logic [CW-1:0] LAST_OPEN = CW'(PAUSE - 1);
  localparam bit            PROC      = (ORDER == "processing");

  logic [CW-1:0]    r_ctr;
  logic [WIDTH-1:0] r_dout;
  logic             w_open;
  logic             w_unused_tready;

  // Counter wraps MAX_CNT-1 -> 0 for free because MAX_CNT is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ctr <= CTR_INIT;
    else     r_ctr <= r_ctr + 1'b1;
  end

  always_comb w_open = (r_ctr <= LAST_OPEN);

  generate
    if (PROC) begin : g_proc
      logic [WIDTH-1:0] r_hi;

      // Count down through each M-sized block, then jump to the top of the next one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dout <= WIDTH'(MAX_CNT - 1);
          r_hi   <= WIDTH'(MAX_CNT);
        end else if (w_open) begin
          if (r_dout[CW-1:0] == '0) r_dout <= r_hi - 1'b1;
          else                      r_dout <= r_dout - 1'b1;
          if (r_dout[CW-1:0] == CW'(1)) r_hi <= r_hi + WIDTH'(MAX_CNT);
        end
      end
    end else begin : g_nat
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_dout <= '0;
        else if (w_open) r_dout <= r_dout + 1'b1;
      end
    end
  endgenerate

  // The source cannot be back-pressured; tready is deliberately ignored.
  assign w_unused_tready = m_axis.tready;

  assign m_axis.tdata  = r_dout;
  assign m_axis.tvalid = w_open;

endmodule

// File: tb/tb_axis.sv
// Checks four parameterisations of the ramp source against table vectors and a
// closed-form reference model, with random tready and asynchronous mid-stream resets.
module tb_axis;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  axis_if #(.WIDTH(16)) if_a ();
  axis_if #(.WIDTH(16)) if_b ();
  axis_if #(.WIDTH(16)) if_c ();
  axis_if #(.WIDTH(4))  if_d ();

  axis #(.WIDTH(16), .MAX_CNT(64), .START(47), .PAUSE(48), .ORDER("natural"))
    u_a (.clk(clk), .rst(rst), .m_axis(if_a));
  axis #(.WIDTH(16), .MAX_CNT(32), .START(0), .PAUSE(32), .ORDER("processing"))
    u_b (.clk(clk), .rst(rst), .m_axis(if_b));
  axis #(.WIDTH(16), .MAX_CNT(32), .START(23), .PAUSE(24), .ORDER("processing"))
    u_c (.clk(clk), .rst(rst), .m_axis(if_c));
  axis #(.WIDTH(4), .MAX_CNT(32), .START(0), .PAUSE(32), .ORDER("natural"))
    u_d (.clk(clk), .rst(rst), .m_axis(if_d));

  logic [15:0] act_d [4];
  logic        act_v [4];
  always_comb begin
    act_d[0] = if_a.tdata;  act_v[0] = if_a.tvalid;
    act_d[1] = if_b.tdata;  act_v[1] = if_b.tvalid;
    act_d[2] = if_c.tdata;  act_v[2] = if_c.tvalid;
    act_d[3] = {12'd0, if_d.tdata}; act_v[3] = if_d.tvalid;
  end

  // Reference: cycle k after reset release. The ramp value is a function of how
  // many open cycles preceded k; processing order reverses each M-block.
  function automatic void model(input int d, input int k,
                                output logic [15:0] ed, output logic ev);
    int m, p, s, w, n, v;
    bit proc;
    case (d)
      0:       begin m = 64; p = 48; s = 47; w = 16; proc = 1'b0; end
      1:       begin m = 32; p = 32; s = 0;  w = 16; proc = 1'b1; end
      2:       begin m = 32; p = 24; s = 23; w = 16; proc = 1'b1; end
      default: begin m = 32; p = 32; s = 0;  w = 4;  proc = 1'b0; end
    endcase
    n = 0;
    for (int j = 0; j < k; j++)
      if (((s + j) % m) < p) n++;
    ev = (((s + k) % m) < p);
    v  = proc ? ((n / m) * m + (m - 1 - (n % m))) : n;
    ed = 16'(v % (1 << w));
  endfunction

  task automatic chk(input string nm, input int d, input int k, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut=%0d cycle=%0d actual=%0d required=%0d", nm, d, k, a, e);
    end
  endtask

  task automatic chk_model(input string nm, input int k);
    logic [15:0] ed;
    logic        ev;
    for (int d = 0; d < 4; d++) begin
      model(d, k, ed, ev);
      chk({nm, "_data"},  d, k, int'(act_d[d]), int'(ed));
      chk({nm, "_valid"}, d, k, int'(act_v[d]), int'(ev));
    end
  endtask

  always @(negedge clk) begin
    if_a.tready = 1'($urandom);
    if_b.tready = 1'($urandom);
    if_c.tready = 1'($urandom);
    if_d.tready = 1'($urandom);
  end

  typedef struct {
    int          dut;
    int          cyc;
    logic [15:0] data;
    logic        valid;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int len;
    vecs = '{
      '{0, 0, 16'd0, 1'b1},  '{0, 1, 16'd1, 1'b0},  '{0, 16, 16'd1, 1'b0},
      '{0, 17, 16'd1, 1'b1}, '{0, 64, 16'd48, 1'b1}, '{0, 65, 16'd49, 1'b0},
      '{0, 80, 16'd49, 1'b0}, '{0, 81, 16'd49, 1'b1},
      '{1, 0, 16'd31, 1'b1}, '{1, 31, 16'd0, 1'b1},  '{1, 32, 16'd63, 1'b1},
      '{1, 63, 16'd32, 1'b1}, '{1, 64, 16'd95, 1'b1},
      '{2, 0, 16'd31, 1'b1}, '{2, 1, 16'd30, 1'b0},  '{2, 8, 16'd30, 1'b0},
      '{2, 9, 16'd30, 1'b1}, '{2, 32, 16'd7, 1'b1},  '{2, 33, 16'd6, 1'b0},
      '{3, 0, 16'd0, 1'b1},  '{3, 15, 16'd15, 1'b1}, '{3, 16, 16'd0, 1'b1},
      '{3, 17, 16'd1, 1'b1}
    };

    repeat (3) @(negedge clk);
    #1 chk_model("reset", 0);

    // Table phase from the first reset release.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 90; k++) begin
      #1;
      foreach (vecs[i]) begin
        if (vecs[i].cyc == k) begin
          chk("tbl_data",  vecs[i].dut, k, int'(act_d[vecs[i].dut]), int'(vecs[i].data));
          chk("tbl_valid", vecs[i].dut, k, int'(act_v[vecs[i].dut]), int'(vecs[i].valid));
        end
      end
      chk_model("run", k);
      @(negedge clk);
    end

    // Random-length segments, each ended by a reset asserted between clock edges.
    for (int seg = 0; seg < 6; seg++) begin
      len = int'($urandom_range(10, 140));
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_model("async_rst", 0);
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < len; k++) begin
        #1 chk_model("seg", k);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
